pio_ctrl: RTL and testbench

- Parametrised host-command and configuration block for the PIO top: NUM_SM state machines instead of a fixed 4, and IMEM_DEPTH instruction words instead of a fixed 32.
- Holds the shared instruction memory and all per-machine configuration registers, and exports both as packed buses to the machine and FIFO instances.
- Adds behaviour the current design lacks: command validation, FIFO push/pull guarding with a response handshake, sticky overflow flags, and OR/priority combining of GPIO outputs from all machines.

---
 rtl/pio_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pio_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_ctrl.sv
// pio_ctrl: PIO host-command decoder with shared instruction memory, per-machine configuration,
// guarded FIFO push/pull and GPIO combining. Define PIO_CTRL_READBACK_EN for action-18 readback and overflow flags.
module pio_ctrl #(
    parameter int NUM_SM     = 4,
    parameter int IMEM_DEPTH = 32,
    localparam int SW = (NUM_SM > 1) ? $clog2(NUM_SM) : 1,
    localparam int AW = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SW-1:0]        mindex,
    input  logic [AW-1:0]        index,
    input  logic [4:0]           action,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    input  logic [NUM_SM*AW-1:0] pc,
    output logic [NUM_SM*16-1:0] instr,
    output logic                 imm,
    output logic [NUM_SM-1:0]    en,
    output logic [NUM_SM-1:0]    jmp_pin,
    output logic [NUM_SM-1:0]    auto_push,
    output logic [NUM_SM-1:0]    auto_pull,
    output logic [NUM_SM*AW-1:0] pstart,
    output logic [NUM_SM*AW-1:0] pend,
    output logic [NUM_SM*24-1:0] div,
    output logic [NUM_SM*32-1:0] pins_cfg,
    output logic [NUM_SM*3-1:0]  sideset_bits,
    output logic [NUM_SM*32-1:0] initial_pins,
    output logic [NUM_SM*32-1:0] initial_dirs,
    output logic [NUM_SM*5-1:0]  isr_threshold,
    output logic [NUM_SM*5-1:0]  osr_threshold,
    output logic [NUM_SM-1:0]    tx_push,
    output logic [NUM_SM-1:0]    rx_pull,
    input  logic [NUM_SM-1:0]    tx_full,
    input  logic [NUM_SM-1:0]    rx_empty,
    input  logic [NUM_SM*32-1:0] rx_data,
    input  logic [NUM_SM*32-1:0] sm_out,
    input  logic [NUM_SM*32-1:0] sm_dir,
    output logic [31:0]          gpio_out,
    output logic [31:0]          gpio_dir
);

    localparam logic [4:0] A_IMEM   = 5'd1;
    localparam logic [4:0] A_PEND   = 5'd2;
    localparam logic [4:0] A_PULL   = 5'd3;
    localparam logic [4:0] A_PUSH   = 5'd4;
    localparam logic [4:0] A_PINS   = 5'd5;
    localparam logic [4:0] A_EN     = 5'd6;
    localparam logic [4:0] A_DIV    = 5'd7;
    localparam logic [4:0] A_SIDE   = 5'd8;
    localparam logic [4:0] A_IMM    = 5'd9;
    localparam logic [4:0] A_APUSH  = 5'd10;
    localparam logic [4:0] A_APULL  = 5'd11;
    localparam logic [4:0] A_IPINS  = 5'd12;
    localparam logic [4:0] A_IDIRS  = 5'd13;
    localparam logic [4:0] A_THR    = 5'd14;
    localparam logic [4:0] A_JMP    = 5'd16;
    localparam logic [4:0] A_PSTART = 5'd17;

    logic [15:0] imem [IMEM_DEPTH];
    logic        sm_ok;

    // Commands aimed at a non-existent machine are dropped (imem writes excepted).
    assign sm_ok = 32'(mindex) < NUM_SM;
    assign imm   = !reset && sm_ok && (action == A_IMM);

    always_ff @(posedge clk) begin
        if (!reset && action == A_IMEM)
            imem[index] <= din[15:0];
    end

    for (genvar j = 0; j < NUM_SM; j++) begin : g_lane
        assign instr[j*16 +: 16] = imm ? din[15:0] : imem[pc[j*AW +: AW]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en            <= '0;
            jmp_pin       <= '0;
            auto_push     <= '0;
            auto_pull     <= '0;
            pstart        <= '0;
            pend          <= '0;
            div           <= '0;
            pins_cfg      <= '0;
            sideset_bits  <= '0;
            initial_pins  <= '0;
            initial_dirs  <= '0;
            isr_threshold <= '0;
            osr_threshold <= '0;
        end else if (sm_ok) begin
            case (action)
                A_PEND:   pend[mindex*AW +: AW]         <= index;
                A_PSTART: pstart[mindex*AW +: AW]       <= index;
                A_PINS:   pins_cfg[mindex*32 +: 32]     <= din;
                A_EN:     en                            <= din[NUM_SM-1:0];
                A_DIV:    div[mindex*24 +: 24]          <= din[23:0];
                A_SIDE:   sideset_bits[mindex*3 +: 3]   <= din[2:0];
                A_APUSH:  auto_push                     <= din[NUM_SM-1:0];
                A_APULL:  auto_pull                     <= din[NUM_SM-1:0];
                A_IPINS:  initial_pins[mindex*32 +: 32] <= din;
                A_IDIRS:  initial_dirs[mindex*32 +: 32] <= din;
                A_THR: begin
                    isr_threshold[mindex*5 +: 5] <= din[4:0];
                    osr_threshold[mindex*5 +: 5] <= din[9:5];
                end
                A_JMP:    jmp_pin                       <= din[NUM_SM-1:0];
                default: ;
            endcase
        end
    end

`ifdef PIO_CTRL_READBACK_EN
    localparam logic [4:0] A_READ = 5'd18;

    logic [NUM_SM-1:0] ovf;
    logic [31:0]       rb_word;

    always_comb begin
        rb_word = '0;
        case (index[2:0])
            3'd0:    rb_word = {8'd0, div[mindex*24 +: 24]};
            3'd1:    rb_word = pins_cfg[mindex*32 +: 32];
            3'd2:    rb_word = initial_pins[mindex*32 +: 32];
            3'd3:    rb_word = initial_dirs[mindex*32 +: 32];
            3'd4:    rb_word = {22'd0, osr_threshold[mindex*5 +: 5], isr_threshold[mindex*5 +: 5]};
            3'd5:    rb_word = 32'({pstart[mindex*AW +: AW], pend[mindex*AW +: AW]});
            3'd6:    rb_word = {8'(en), 8'(auto_push), 8'(auto_pull), 8'(jmp_pin)};
            default: rb_word = 32'(ovf);
        endcase
    end

    // Overflow flags are sticky until read back through index 7.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= '0;
        end else if (sm_ok) begin
            if (action == A_READ && index[2:0] == 3'd7)
                ovf <= '0;
            if (action == A_PUSH && tx_full[mindex])
                ovf[mindex] <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_push   <= '0;
            rx_pull   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            dout      <= '0;
        end else begin
            tx_push   <= '0;
            rx_pull   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (sm_ok && action == A_PUSH && !tx_full[mindex])
                tx_push[mindex] <= 1'b1;
            if (sm_ok && action == A_PULL) begin
                rsp_valid <= 1'b1;
                if (rx_empty[mindex]) begin
                    rsp_err <= 1'b1;
                    dout    <= '0;
                end else begin
                    rx_pull[mindex] <= 1'b1;
                    dout            <= rx_data[mindex*32 +: 32];
                end
            end
`ifdef PIO_CTRL_READBACK_EN
            if (sm_ok && action == A_READ) begin
                rsp_valid <= 1'b1;
                dout      <= rb_word;
            end
`endif
        end
    end

    // Later machines overwrite earlier ones, so the highest driving index wins each pad.
    always_comb begin
        gpio_out = '0;
        gpio_dir = '0;
        for (int j = 0; j < NUM_SM; j++) begin
            gpio_out = (gpio_out & ~sm_dir[j*32 +: 32]) | (sm_out[j*32 +: 32] & sm_dir[j*32 +: 32]);
            gpio_dir = gpio_dir | sm_dir[j*32 +: 32];
        end
    end

endmodule

// File: tb/tb_pio_ctrl.sv
// tb_pio_ctrl: randomized scoreboard bench for pio_ctrl (NUM_SM=3 so an out-of-range mindex exists).
// Readback expectations are included when PIO_CTRL_READBACK_EN is defined.
module tb_pio_ctrl;
    localparam int NUM_SM     = 3;
    localparam int IMEM_DEPTH = 32;
    localparam int SW         = 2;
    localparam int AW         = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [SW-1:0]        mindex;
    logic [AW-1:0]        index;
    logic [4:0]           action;
    logic [31:0]          din;
    logic [31:0]          dout;
    logic                 rsp_valid, rsp_err;
    logic [NUM_SM*AW-1:0] pc;
    logic [NUM_SM*16-1:0] instr;
    logic                 imm;
    logic [NUM_SM-1:0]    en, jmp_pin, auto_push, auto_pull;
    logic [NUM_SM*AW-1:0] pstart, pend;
    logic [NUM_SM*24-1:0] div;
    logic [NUM_SM*32-1:0] pins_cfg, initial_pins, initial_dirs;
    logic [NUM_SM*3-1:0]  sideset_bits;
    logic [NUM_SM*5-1:0]  isr_threshold, osr_threshold;
    logic [NUM_SM-1:0]    tx_push, rx_pull, tx_full, rx_empty;
    logic [NUM_SM*32-1:0] rx_data, sm_out, sm_dir;
    logic [31:0]          gpio_out, gpio_dir;

    pio_ctrl #(.NUM_SM(NUM_SM), .IMEM_DEPTH(IMEM_DEPTH)) dut (
        .clk(clk), .reset(reset), .mindex(mindex), .index(index), .action(action), .din(din),
        .dout(dout), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .pc(pc), .instr(instr), .imm(imm),
        .en(en), .jmp_pin(jmp_pin), .auto_push(auto_push), .auto_pull(auto_pull),
        .pstart(pstart), .pend(pend), .div(div), .pins_cfg(pins_cfg), .sideset_bits(sideset_bits),
        .initial_pins(initial_pins), .initial_dirs(initial_dirs),
        .isr_threshold(isr_threshold), .osr_threshold(osr_threshold),
        .tx_push(tx_push), .rx_pull(rx_pull), .tx_full(tx_full), .rx_empty(rx_empty),
        .rx_data(rx_data), .sm_out(sm_out), .sm_dir(sm_dir), .gpio_out(gpio_out), .gpio_dir(gpio_dir)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [31:0]       dout;
        logic              valid;
        logic              err;
        logic [NUM_SM-1:0] push;
        logic [NUM_SM-1:0] pull;
    } exp_t;
    exp_t q[$];

    // Reference state, one entry per machine
    logic [15:0]       m_imem    [IMEM_DEPTH];
    logic              m_imem_ok [IMEM_DEPTH];
    logic [AW-1:0]     m_pstart  [NUM_SM];
    logic [AW-1:0]     m_pend    [NUM_SM];
    logic [23:0]       m_div     [NUM_SM];
    logic [31:0]       m_pins    [NUM_SM];
    logic [31:0]       m_ipins   [NUM_SM];
    logic [31:0]       m_idirs   [NUM_SM];
    logic [2:0]        m_side    [NUM_SM];
    logic [4:0]        m_isr     [NUM_SM];
    logic [4:0]        m_osr     [NUM_SM];
    logic [NUM_SM-1:0] m_en, m_apush, m_apull, m_jmp;
`ifdef PIO_CTRL_READBACK_EN
    logic [NUM_SM-1:0] m_ovf;
`endif

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NUM_SM; j++) begin
            m_pstart[j] = '0; m_pend[j] = '0; m_div[j] = '0; m_pins[j] = '0;
            m_ipins[j] = '0; m_idirs[j] = '0; m_side[j] = '0; m_isr[j] = '0; m_osr[j] = '0;
        end
        m_en = '0; m_apush = '0; m_apull = '0; m_jmp = '0;
`ifdef PIO_CTRL_READBACK_EN
        m_ovf = '0;
`endif
    endtask

    task automatic model_cmd();
        int   mi;
        exp_t e;
        mi = int'(mindex);
        if (action == 5'd1) begin
            m_imem[index]    = din[15:0];
            m_imem_ok[index] = 1'b1;
        end
        if (mi >= NUM_SM) return;
        e.cyc = cyc + 1; e.dout = '0; e.valid = 1'b0; e.err = 1'b0; e.push = '0; e.pull = '0;
        case (int'(action))
            2:  m_pend[mi]   = index;
            17: m_pstart[mi] = index;
            5:  m_pins[mi]   = din;
            6:  m_en         = din[NUM_SM-1:0];
            7:  m_div[mi]    = din[23:0];
            8:  m_side[mi]   = din[2:0];
            10: m_apush      = din[NUM_SM-1:0];
            11: m_apull      = din[NUM_SM-1:0];
            12: m_ipins[mi]  = din;
            13: m_idirs[mi]  = din;
            14: begin m_isr[mi] = din[4:0]; m_osr[mi] = din[9:5]; end
            16: m_jmp        = din[NUM_SM-1:0];
            4: begin
                if (!tx_full[mi]) begin
                    e.push[mi] = 1'b1;
                    q.push_back(e);
                end
`ifdef PIO_CTRL_READBACK_EN
                else m_ovf[mi] = 1'b1;
`endif
            end
            3: begin
                e.valid = 1'b1;
                if (rx_empty[mi]) e.err = 1'b1;
                else begin
                    e.dout     = rx_data[mi*32 +: 32];
                    e.pull[mi] = 1'b1;
                end
                q.push_back(e);
            end
`ifdef PIO_CTRL_READBACK_EN
            18: begin
                e.valid = 1'b1;
                case (int'(index[2:0]))
                    0: e.dout = 32'(m_div[mi]);
                    1: e.dout = m_pins[mi];
                    2: e.dout = m_ipins[mi];
                    3: e.dout = m_idirs[mi];
                    4: e.dout = 32'(m_osr[mi]) * 32 + 32'(m_isr[mi]);
                    5: e.dout = 32'(m_pstart[mi]) * IMEM_DEPTH + 32'(m_pend[mi]);
                    6: e.dout = 32'(m_en) * 32'h0100_0000 + 32'(m_apush) * 32'h1_0000
                               + 32'(m_apull) * 32'h100 + 32'(m_jmp);
                    default: begin e.dout = 32'(m_ovf); m_ovf = '0; end
                endcase
                q.push_back(e);
            end
`endif
            default: ;
        endcase
    endtask

    task automatic check_comb();
        logic        imm_e;
        logic [15:0] lane_e;
        logic [31:0] go, gd;
        int          a;
        imm_e = !reset && action == 5'd9 && int'(mindex) < NUM_SM;
        chk("imm", 128'(imm), 128'(imm_e));
        for (int j = 0; j < NUM_SM; j++) begin
            a = int'(pc[j*AW +: AW]);
            lane_e = imm_e ? din[15:0] : m_imem[a];
            if (imm_e || m_imem_ok[a])
                chk($sformatf("instr_lane%0d", j), 128'(instr[j*16 +: 16]), 128'(lane_e));
        end
        go = '0; gd = '0;
        for (int b = 0; b < 32; b++)
            for (int j = 0; j < NUM_SM; j++)
                if (sm_dir[j*32 + b]) begin
                    gd[b] = 1'b1;
                    go[b] = sm_out[j*32 + b];
                end
        chk("gpio_out", 128'(gpio_out), 128'(go));
        chk("gpio_dir", 128'(gpio_dir), 128'(gd));
    endtask

    task automatic check_cfg();
        logic [NUM_SM*AW-1:0] e_ps, e_pe;
        logic [NUM_SM*24-1:0] e_div;
        logic [NUM_SM*32-1:0] e_pins, e_ip, e_id;
        logic [NUM_SM*3-1:0]  e_sd;
        logic [NUM_SM*5-1:0]  e_isr, e_osr;
        for (int j = 0; j < NUM_SM; j++) begin
            e_ps[j*AW +: AW] = m_pstart[j]; e_pe[j*AW +: AW] = m_pend[j];
            e_div[j*24 +: 24] = m_div[j];   e_pins[j*32 +: 32] = m_pins[j];
            e_ip[j*32 +: 32] = m_ipins[j];  e_id[j*32 +: 32] = m_idirs[j];
            e_sd[j*3 +: 3] = m_side[j];     e_isr[j*5 +: 5] = m_isr[j]; e_osr[j*5 +: 5] = m_osr[j];
        end
        chk("pstart", 128'(pstart), 128'(e_ps));
        chk("pend", 128'(pend), 128'(e_pe));
        chk("div", 128'(div), 128'(e_div));
        chk("pins_cfg", 128'(pins_cfg), 128'(e_pins));
        chk("initial_pins", 128'(initial_pins), 128'(e_ip));
        chk("initial_dirs", 128'(initial_dirs), 128'(e_id));
        chk("sideset_bits", 128'(sideset_bits), 128'(e_sd));
        chk("isr_threshold", 128'(isr_threshold), 128'(e_isr));
        chk("osr_threshold", 128'(osr_threshold), 128'(e_osr));
        chk("en", 128'(en), 128'(m_en));
        chk("auto_push", 128'(auto_push), 128'(m_apush));
        chk("auto_pull", 128'(auto_pull), 128'(m_apull));
        chk("jmp_pin", 128'(jmp_pin), 128'(m_jmp));
    endtask

    task automatic step(input logic r, input logic [4:0] a, input int mi, input int idx, input logic [31:0] d);
        logic [31:0] miv, idxv;
        miv = mi; idxv = idx;
        reset = r; action = a; mindex = miv[SW-1:0]; index = idxv[AW-1:0]; din = d;
        #1;
        check_comb();
        if (r) model_reset();
        else   model_cmd();
        @(posedge clk);
        #1;
        check_cfg();
    endtask

    // Response monitor: pops one expectation per presented strobe or response
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid || tx_push != '0 || rx_pull != '0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: rsp_valid=%b err=%b dout=%h tx_push=%b rx_pull=%b, none expected",
                         rsp_valid, rsp_err, dout, tx_push, rx_pull);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || rsp_valid !== e.valid || tx_push !== e.push || rx_pull !== e.pull ||
                    (e.valid && (rsp_err !== e.err || dout !== e.dout))) begin
                    errors++;
                    $display("FAIL response: got cyc=%0d v=%b err=%b dout=%h push=%b pull=%b required cyc=%0d v=%b err=%b dout=%h push=%b pull=%b",
                             cyc, rsp_valid, rsp_err, dout, tx_push, rx_pull,
                             e.cyc, e.valid, e.err, e.dout, e.push, e.pull);
                end
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing_output: nothing presented at cyc %0d, required v=%b dout=%h push=%b pull=%b",
                     cyc, e.valid, e.dout, e.push, e.pull);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) m_imem_ok[i] = 1'b0;
        model_reset();
        pc = '0; tx_full = '0; rx_empty = '1; rx_data = '0; sm_out = '0; sm_dir = '0;
        step(1'b1, 5'd0, 0, 0, 32'h0);
        step(1'b1, 5'd0, 0, 0, 32'h0);
        chk("dout_reset", 128'(dout), 128'(0));
        chk("rsp_valid_reset", 128'(rsp_valid), 128'(0));
        chk("rsp_err_reset", 128'(rsp_err), 128'(0));
        chk("tx_push_reset", 128'(tx_push), 128'(0));
        chk("rx_pull_reset", 128'(rx_pull), 128'(0));

        for (int i = 0; i < IMEM_DEPTH; i++) step(1'b0, 5'd1, 0, i, $urandom);
        step(1'b0, 5'd1, 0, 5, 32'h0000_E081);
        pc[2*AW +: AW] = 5'd5;
        step(1'b0, 5'd0, 0, 0, 32'h0);
        chk("instr_lane2_E081", 128'(instr[47:32]), 128'(16'hE081));
        step(1'b0, 5'd9, 0, 0, 32'h0000_A042);
        step(1'b0, 5'd0, 0, 0, 32'h0000_A042);

        tx_full = 3'b000;
        step(1'b0, 5'd4, 1, 0, 32'h1234_5678);
        tx_full = 3'b010;
        step(1'b0, 5'd4, 1, 0, 32'h1234_5678);
        step(1'b0, 5'd0, 0, 0, 32'h0);
`ifdef PIO_CTRL_READBACK_EN
        step(1'b0, 5'd18, 1, 7, 32'h0);
        step(1'b0, 5'd18, 1, 7, 32'h0);
`endif
        rx_empty = 3'b011; rx_data[2*32 +: 32] = 32'hDEAD_BEEF;
        step(1'b0, 5'd3, 2, 0, 32'h0);
        rx_empty = 3'b111;
        step(1'b0, 5'd3, 2, 0, 32'h0);
        rx_empty = 3'b000; rx_data[31:0] = 32'h0BAD_F00D;
        step(1'b0, 5'd3, 0, 0, 32'h0);
        rx_data[31:0] = 32'h5555_AAAA;
        step(1'b0, 5'd3, 0, 0, 32'h0);

        sm_dir = '0; sm_out = '0;
        sm_dir[0] = 1'b1; sm_dir[64] = 1'b1; sm_out[0] = 1'b1; sm_out[64] = 1'b0;
        step(1'b0, 5'd0, 0, 0, 32'h0);
        chk("gpio_out0_hi_prio", 128'(gpio_out[0]), 128'(0));
        sm_dir[64] = 1'b0;
        step(1'b0, 5'd0, 0, 0, 32'h0);
        chk("gpio_out0_m0", 128'(gpio_out[0]), 128'(1));

        step(1'b0, 5'd7, 3, 0, 32'd100);
        step(1'b0, 5'd3, 3, 0, 32'd0);
        step(1'b0, 5'd14, 1, 0, 32'h0000_0148);
        chk("isr_m1", 128'(isr_threshold[9:5]), 128'(8));
        chk("osr_m1", 128'(osr_threshold[9:5]), 128'(10));
`ifdef PIO_CTRL_READBACK_EN
        step(1'b0, 5'd18, 1, 4, 32'h0);
`endif
        step(1'b0, 5'd11, 0, 0, 32'd1);
        step(1'b0, 5'd16, 0, 0, 32'd2);
        step(1'b0, 5'd2, 1, 9, 32'd0);
        step(1'b0, 5'd17, 1, 3, 32'd0);
        step(1'b1, 5'd7, 0, 0, 32'd55);

        for (int i = 0; i < 800; i++) begin
            pc       = 15'($urandom);
            tx_full  = 3'($urandom);
            rx_empty = 3'($urandom);
            rx_data  = {$urandom, $urandom, $urandom};
            sm_out   = {$urandom, $urandom, $urandom};
            sm_dir   = {$urandom, $urandom, $urandom};
            step($urandom_range(0, 39) == 0, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                 $urandom_range(0, 31), $urandom);
        end

        step(1'b0, 5'd0, 0, 0, 32'h0);
        step(1'b0, 5'd0, 0, 0, 32'h0);
        @(negedge clk);
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
